el2_dec_gpr_wb_sb: RTL and testbench

GPR writeback scoreboard and write-port driver in dec, i.e. the producer side of the 3-write-port GPR file.
- Tracks destination registers of outstanding non-blocking loads (NBL) and the non-blocking divider.
- Reports busy sources/destination to decode.
- Merges pipe, load-return and divide-return writebacks onto write ports 0/1/2.
- Resolves WAW and same-cycle collisions so no two ports ever write the same GPR in one cycle.

---
 rtl/el2_dec_gpr_wb_sb_pkg.sv | 31 +++
 rtl/el2_dec_gpr_wb_sb_if.sv | 65 ++++++
 rtl/el2_dec_gpr_sb_entry.sv | 59 +++++
 rtl/el2_dec_gpr_wb_sb.sv | 140 ++++++++++++++
 tb/tb_el2_dec_gpr_wb_sb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/el2_dec_gpr_wb_sb_pkg.sv
// Shared types and constants for the GPR writeback scoreboard.
// Optional statistics counter is enabled by defining GPR_WB_SB_STAT_EN.
package el2_dec_gpr_wb_sb_pkg;

   localparam int NBL_DEPTH_DEF = 4;
   localparam int NBL_TAG_W_DEF = $clog2(NBL_DEPTH_DEF);

   // Query addresses compared against every entry in parallel
   localparam int NQ     = 6;
   localparam int Q_RS0  = 0;
   localparam int Q_RS1  = 1;
   localparam int Q_RD   = 2;
   localparam int Q_PIPE = 3;
   localparam int Q_NBL  = 4;
   localparam int Q_DIV  = 5;

   // One pending-write record: live=0 means the eventual return is discarded
   typedef struct packed {
      logic       valid;
      logic       live;
      logic [4:0] rd;
   } el2_gpr_sb_entry_t;

   // 16-bit saturating add of a small increment
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/el2_dec_gpr_wb_sb_if.sv
// Interface bundling the scoreboard's issue, return, writeback, decode and
// write-port signals. Every *_valid (and div_cancel) qualifies its payload for
// exactly one cycle; there is no back-pressure, the scoreboard always accepts.
interface el2_dec_gpr_wb_sb_if #(
   parameter int NBL_TAG_W = 2
);
   logic                 nbl_issue_valid;
   logic [NBL_TAG_W-1:0] nbl_issue_tag;
   logic [4:0]           nbl_issue_rd;
   logic                 nbl_cancel_valid;
   logic [NBL_TAG_W-1:0] nbl_cancel_tag;
   logic                 nbl_ret_valid;
   logic [NBL_TAG_W-1:0] nbl_ret_tag;
   logic [31:0]          nbl_ret_data;
   logic                 div_issue_valid;
   logic [4:0]           div_issue_rd;
   logic                 div_cancel;
   logic                 div_ret_valid;
   logic [31:0]          div_ret_data;
   logic                 pipe_wb_valid;
   logic [4:0]           pipe_wb_rd;
   logic [31:0]          pipe_wb_data;
   logic [4:0]           raddr0;
   logic [4:0]           raddr1;
   logic [4:0]           dec_rd;
   logic                 rs0_busy;
   logic                 rs1_busy;
   logic                 rd_busy;
   logic                 nbl_full;
   logic                 wen0;
   logic [4:0]           waddr0;
   logic [31:0]          wd0;
   logic                 wen1;
   logic [4:0]           waddr1;
   logic [31:0]          wd1;
   logic                 wen2;
   logic [4:0]           waddr2;
   logic [31:0]          wd2;
   logic [15:0]          stale_cnt;
   logic                 sb_err;

   modport master (
      output nbl_issue_valid, nbl_issue_tag, nbl_issue_rd,
      output nbl_cancel_valid, nbl_cancel_tag,
      output nbl_ret_valid, nbl_ret_tag, nbl_ret_data,
      output div_issue_valid, div_issue_rd, div_cancel, div_ret_valid, div_ret_data,
      output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
      output raddr0, raddr1, dec_rd,
      input  rs0_busy, rs1_busy, rd_busy, nbl_full,
      input  wen0, waddr0, wd0, wen1, waddr1, wd1, wen2, waddr2, wd2,
      input  stale_cnt, sb_err
   );

   modport slave (
      input  nbl_issue_valid, nbl_issue_tag, nbl_issue_rd,
      input  nbl_cancel_valid, nbl_cancel_tag,
      input  nbl_ret_valid, nbl_ret_tag, nbl_ret_data,
      input  div_issue_valid, div_issue_rd, div_cancel, div_ret_valid, div_ret_data,
      input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
      input  raddr0, raddr1, dec_rd,
      output rs0_busy, rs1_busy, rd_busy, nbl_full,
      output wen0, waddr0, wd0, wen1, waddr1, wd1, wen2, waddr2, wd2,
      output stale_cnt, sb_err
   );
endinterface

// File: rtl/el2_dec_gpr_sb_entry.sv
// One scoreboard entry: free clears it, kill drops liveness (a younger write
// owns the register), set loads a new destination. Set has the last word so a
// tag may be freed and re-issued in the same cycle. The flop only toggles when
// one of the controls is active.
module el2_dec_gpr_sb_entry
   import el2_dec_gpr_wb_sb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic                   set_i,
   input  logic [4:0]             set_rd_i,
   input  logic                   kill_i,
   input  logic                   free_i,
   input  logic [NQ-1:0][4:0]     qaddr_i,
   output el2_gpr_sb_entry_t      ent_o,
   output logic [NQ-1:0]          match_o
);

   el2_gpr_sb_entry_t ent_q, ent_d;
   logic              en;

   assign en    = set_i | kill_i | free_i;
   assign ent_o = ent_q;

   // Next-state: free, then kill, then set (latest event wins)
   always_comb begin
      ent_d = ent_q;
      if (free_i) begin
         ent_d = '0;
      end
      if (kill_i) begin
         ent_d.live = 1'b0;
      end
      if (set_i) begin
         ent_d.valid = 1'b1;
         ent_d.live  = (set_rd_i != 5'd0);
         ent_d.rd    = set_rd_i;
      end
   end

   // Enabled entry register with asynchronous clear
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         ent_q <= '0;
      end else if (en) begin
         ent_q <= ent_d;
      end
   end

   // Live-pending match against each query address; x0 never matches
   always_comb begin
      match_o = '0;
      for (int k = 0; k < NQ; k++) begin
         match_o[k] = ent_q.valid & ent_q.live & (ent_q.rd == qaddr_i[k]) &
                      (qaddr_i[k] != 5'd0);
      end
   end

endmodule

// File: rtl/el2_dec_gpr_wb_sb.sv
// GPR writeback scoreboard and write-port driver. Tracks NBL tags and the
// divider destination, reports busy registers to decode and drives the three
// GPR write ports (0 pipe, 1 load return, 2 divide return) combinationally.
// Define GPR_WB_SB_STAT_EN to build the saturating stale-return counter.
module el2_dec_gpr_wb_sb
   import el2_dec_gpr_wb_sb_pkg::*;
#(
   parameter int NBL_DEPTH = NBL_DEPTH_DEF,
   parameter int NBL_TAG_W = $clog2(NBL_DEPTH)
)(
   input logic               clk,
   input logic               rst_l,
   el2_dec_gpr_wb_sb_if.slave sb
);

   localparam int NE      = NBL_DEPTH + 1;
   localparam int DIV_IDX = NBL_DEPTH;

   logic [NE-1:0]       set_v, kill_v, free_v, valid_v;
   el2_gpr_sb_entry_t   ent [NE];
   logic [NQ-1:0]       match [NE];
   logic [NQ-1:0][4:0]  qaddr;

   el2_gpr_sb_entry_t   ret_ent, div_ent, iss_ent;
   logic                nbl_ret_hit, div_ret_act, div_ret_hit;
   logic                wen1, wen2, err_set;
   logic [2:0]          busy_v;
   logic                sb_err_q, sb_err_d;

   assign qaddr[Q_RS0]  = sb.raddr0;
   assign qaddr[Q_RS1]  = sb.raddr1;
   assign qaddr[Q_RD]   = sb.dec_rd;
   assign qaddr[Q_PIPE] = sb.pipe_wb_rd;
   assign qaddr[Q_NBL]  = sb.nbl_issue_rd;
   assign qaddr[Q_DIV]  = sb.div_issue_rd;

   for (genvar i = 0; i < NE; i++) begin : g_ent
      el2_dec_gpr_sb_entry u_ent (
         .clk      (clk),
         .rst_l    (rst_l),
         .set_i    (set_v[i]),
         .set_rd_i ((i < NBL_DEPTH) ? sb.nbl_issue_rd : sb.div_issue_rd),
         .kill_i   (kill_v[i]),
         .free_i   (free_v[i]),
         .qaddr_i  (qaddr),
         .ent_o    (ent[i]),
         .match_o  (match[i])
      );
   end

   // Per-entry set/free/kill decode and busy reduction
   always_comb begin
      set_v   = '0;
      free_v  = '0;
      kill_v  = '0;
      valid_v = '0;
      busy_v  = '0;
      for (int i = 0; i < NBL_DEPTH; i++) begin
         set_v[i]  = sb.nbl_issue_valid & (sb.nbl_issue_tag == NBL_TAG_W'(i));
         free_v[i] = (sb.nbl_ret_valid & (sb.nbl_ret_tag == NBL_TAG_W'(i))) |
                     (sb.nbl_cancel_valid & (sb.nbl_cancel_tag == NBL_TAG_W'(i)));
      end
      set_v[DIV_IDX]  = sb.div_issue_valid;
      free_v[DIV_IDX] = sb.div_cancel | sb.div_ret_valid;
      for (int i = 0; i < NE; i++) begin
         // A younger pipe write or a new issue to the same rd makes older entries stale
         kill_v[i]  = (sb.pipe_wb_valid & match[i][Q_PIPE]) |
                      (sb.nbl_issue_valid & match[i][Q_NBL]) |
                      (sb.div_issue_valid & match[i][Q_DIV]);
         valid_v[i] = ent[i].valid;
         busy_v     = busy_v | {match[i][Q_RS0], match[i][Q_RS1], match[i][Q_RD]};
      end
   end

   // Return qualification, collision suppression and protocol-error detection
   always_comb begin
      ret_ent     = ent[sb.nbl_ret_tag];
      iss_ent     = ent[sb.nbl_issue_tag];
      div_ent     = ent[DIV_IDX];
      nbl_ret_hit = sb.nbl_ret_valid & ret_ent.valid;
      wen1        = nbl_ret_hit & ret_ent.live &
                    ~(sb.pipe_wb_valid & (sb.pipe_wb_rd == ret_ent.rd));
      div_ret_act = sb.div_ret_valid & ~sb.div_cancel;
      div_ret_hit = div_ret_act & div_ent.valid;
      wen2        = div_ret_hit & div_ent.live &
                    ~(sb.pipe_wb_valid & (sb.pipe_wb_rd == div_ent.rd));
      err_set     = (sb.nbl_ret_valid & ~ret_ent.valid) |
                    (div_ret_act & ~div_ent.valid) |
                    (sb.nbl_issue_valid & iss_ent.valid & ~free_v[sb.nbl_issue_tag]) |
                    (sb.div_issue_valid & div_ent.valid & ~free_v[DIV_IDX]);
      sb_err_d    = sb_err_q | err_set;
   end

   // Sticky protocol error flag
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sb_err_q <= 1'b0;
      end else if (err_set) begin
         sb_err_q <= sb_err_d;
      end
   end

   assign sb.rs0_busy = busy_v[2];
   assign sb.rs1_busy = busy_v[1];
   assign sb.rd_busy  = busy_v[0];
   assign sb.nbl_full = &valid_v[NBL_DEPTH-1:0];
   assign sb.sb_err   = sb_err_q;

   assign sb.wen0   = sb.pipe_wb_valid & (sb.pipe_wb_rd != 5'd0);
   assign sb.waddr0 = sb.wen0 ? sb.pipe_wb_rd : 5'd0;
   assign sb.wd0    = sb.wen0 ? sb.pipe_wb_data : 32'd0;
   assign sb.wen1   = wen1;
   assign sb.waddr1 = wen1 ? ret_ent.rd : 5'd0;
   assign sb.wd1    = wen1 ? sb.nbl_ret_data : 32'd0;
   assign sb.wen2   = wen2;
   assign sb.waddr2 = wen2 ? div_ent.rd : 5'd0;
   assign sb.wd2    = wen2 ? sb.div_ret_data : 32'd0;

`ifdef GPR_WB_SB_STAT_EN
   logic [1:0]  stale_inc;
   logic [15:0] stale_q, stale_d;

   assign stale_inc = {1'b0, nbl_ret_hit & ~wen1} + {1'b0, div_ret_hit & ~wen2};
   assign stale_d   = sat_add16(stale_q, stale_inc);

   // Count returns discarded as stale or pipe-colliding
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         stale_q <= 16'd0;
      end else if (stale_inc != 2'd0) begin
         stale_q <= stale_d;
      end
   end

   assign sb.stale_cnt = stale_q;
`else
   assign sb.stale_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_el2_dec_gpr_wb_sb.sv
// Bench for el2_dec_gpr_wb_sb: per-cycle stimulus/expectation records in a
// table, expected outputs queued when driven and compared mid-cycle, plus a
// hand-written asynchronous-reset sequence. GPR_WB_SB_STAT_EN selects the
// stale counter expectations.
module tb_el2_dec_gpr_wb_sb;
   import el2_dec_gpr_wb_sb_pkg::*;

   localparam int W = 135;
`ifdef GPR_WB_SB_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   typedef struct {
      string       name;
      logic        ni_v;  logic [1:0] ni_tag; logic [4:0] ni_rd;
      logic        nc_v;  logic [1:0] nc_tag;
      logic        nr_v;  logic [1:0] nr_tag; logic [31:0] nr_data;
      logic        di_v;  logic [4:0] di_rd;  logic dc;
      logic        dr_v;  logic [31:0] dr_data;
      logic        pw_v;  logic [4:0] pw_rd;  logic [31:0] pw_data;
      logic [4:0]  ra0, ra1, drd;
      logic [37:0] e_p0, e_p1, e_p2;
      logic [2:0]  e_busy;
      logic        e_full, e_err;
      logic [15:0] e_stale;
   } vec_t;

   logic clk = 1'b0;
   logic rst_l = 1'b0;

   el2_dec_gpr_wb_sb_if #(.NBL_TAG_W(2)) sbif ();

   el2_dec_gpr_wb_sb #(.NBL_DEPTH(4), .NBL_TAG_W(2)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .sb    (sbif)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] exp_q[$];
   vec_t        vecs[$];
   logic        exp_err = 1'b0;
   logic [15:0] exp_stale = 16'd0;

   function automatic logic [37:0] wp(input logic [4:0] a, input logic [31:0] d);
      return {1'b1, a, d};
   endfunction

   function automatic vec_t mk(input string name);
      vec_t r;
      r.name = name;
      r.ni_v = 0; r.ni_tag = 0; r.ni_rd = 0; r.nc_v = 0; r.nc_tag = 0;
      r.nr_v = 0; r.nr_tag = 0; r.nr_data = 0;
      r.di_v = 0; r.di_rd = 0; r.dc = 0; r.dr_v = 0; r.dr_data = 0;
      r.pw_v = 0; r.pw_rd = 0; r.pw_data = 0;
      r.ra0 = 0; r.ra1 = 0; r.drd = 0;
      r.e_p0 = 0; r.e_p1 = 0; r.e_p2 = 0; r.e_busy = 0; r.e_full = 0;
      r.e_err = exp_err;
      r.e_stale = STAT ? exp_stale : 16'd0;
      return r;
   endfunction

   function automatic logic [W-1:0] exp_word(input vec_t r);
      return {r.e_p0, r.e_p1, r.e_p2, r.e_busy, r.e_full, r.e_err, r.e_stale};
   endfunction

   function automatic logic [W-1:0] act_word();
      return {sbif.wen0, sbif.waddr0, sbif.wd0, sbif.wen1, sbif.waddr1, sbif.wd1,
              sbif.wen2, sbif.waddr2, sbif.wd2,
              sbif.rs0_busy, sbif.rs1_busy, sbif.rd_busy, sbif.nbl_full,
              sbif.sb_err, sbif.stale_cnt};
   endfunction

   task automatic drive(input vec_t r);
      sbif.nbl_issue_valid  = r.ni_v; sbif.nbl_issue_tag = r.ni_tag; sbif.nbl_issue_rd = r.ni_rd;
      sbif.nbl_cancel_valid = r.nc_v; sbif.nbl_cancel_tag = r.nc_tag;
      sbif.nbl_ret_valid    = r.nr_v; sbif.nbl_ret_tag = r.nr_tag; sbif.nbl_ret_data = r.nr_data;
      sbif.div_issue_valid  = r.di_v; sbif.div_issue_rd = r.di_rd; sbif.div_cancel = r.dc;
      sbif.div_ret_valid    = r.dr_v; sbif.div_ret_data = r.dr_data;
      sbif.pipe_wb_valid    = r.pw_v; sbif.pipe_wb_rd = r.pw_rd; sbif.pipe_wb_data = r.pw_data;
      sbif.raddr0 = r.ra0; sbif.raddr1 = r.ra1; sbif.dec_rd = r.drd;
   endtask

   task automatic check(input string name);
      logic [W-1:0] a, e;
      a = act_word();
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected entry queued, got=%h", name, a);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", name, a, e);
         end
      end
   endtask

   task automatic apply(input vec_t r);
      drive(r);
      exp_q.push_back(exp_word(r));
      #3;
      check(r.name);
   endtask

   initial begin
      vec_t r;

      // reset state
      r = mk("reset"); r.ra0 = 5; r.ra1 = 7; r.drd = 9; vecs.push_back(r);

      // 1: simple load issue and return
      r = mk("t1_issue"); r.ni_v = 1; r.ni_tag = 1; r.ni_rd = 5; r.ra0 = 5; vecs.push_back(r);
      r = mk("t1_pend"); r.ra0 = 5; r.ra1 = 5; r.drd = 5; r.e_busy = 3'b111; vecs.push_back(r);
      r = mk("t1_ret"); r.nr_v = 1; r.nr_tag = 1; r.nr_data = 32'hDEADBEEF; r.ra0 = 5;
      r.e_busy = 3'b100; r.e_p1 = wp(5, 32'hDEADBEEF); vecs.push_back(r);
      r = mk("t1_done"); r.ra0 = 5; vecs.push_back(r);

      // 2: WAW between two loads
      r = mk("t2_iss0"); r.ni_v = 1; r.ni_tag = 0; r.ni_rd = 7; vecs.push_back(r);
      r = mk("t2_iss2"); r.ni_v = 1; r.ni_tag = 2; r.ni_rd = 7; r.ra0 = 7; r.e_busy = 3'b100; vecs.push_back(r);
      r = mk("t2_pend"); r.ra0 = 7; r.e_busy = 3'b100; vecs.push_back(r);
      r = mk("t2_ret0"); r.nr_v = 1; r.nr_tag = 0; r.nr_data = 32'h100; r.ra0 = 7; r.e_busy = 3'b100;
      vecs.push_back(r); exp_stale++;
      r = mk("t2_ret2"); r.nr_v = 1; r.nr_tag = 2; r.nr_data = 32'h200; r.ra0 = 7; r.e_busy = 3'b100;
      r.e_p1 = wp(7, 32'h200); vecs.push_back(r);
      r = mk("t2_done"); r.ra0 = 7; vecs.push_back(r);

      // 3: pipe write overtakes a pending load
      r = mk("t3_iss"); r.ni_v = 1; r.ni_tag = 3; r.ni_rd = 9; vecs.push_back(r);
      r = mk("t3_pw"); r.pw_v = 1; r.pw_rd = 9; r.pw_data = 32'h11; r.ra0 = 9; r.e_busy = 3'b100;
      r.e_p0 = wp(9, 32'h11); vecs.push_back(r);
      r = mk("t3_ret"); r.nr_v = 1; r.nr_tag = 3; r.nr_data = 32'h33; r.ra0 = 9;
      vecs.push_back(r); exp_stale++;
      r = mk("t3_after"); r.ra0 = 9; vecs.push_back(r);

      // 4: pipe/divide same-cycle collision, normal divide, cancel beats return
      r = mk("t4_div"); r.di_v = 1; r.di_rd = 4; vecs.push_back(r);
      r = mk("t4_pend"); r.ra0 = 4; r.ra1 = 4; r.e_busy = 3'b110; vecs.push_back(r);
      r = mk("t4_col"); r.pw_v = 1; r.pw_rd = 4; r.pw_data = 32'h44; r.dr_v = 1; r.dr_data = 32'h55;
      r.ra0 = 4; r.e_busy = 3'b100; r.e_p0 = wp(4, 32'h44); vecs.push_back(r); exp_stale++;
      r = mk("t4_free"); r.ra0 = 4; r.di_v = 1; r.di_rd = 6; vecs.push_back(r);
      r = mk("t4_dret"); r.dr_v = 1; r.dr_data = 32'h66; r.ra1 = 6; r.e_busy = 3'b010;
      r.e_p2 = wp(6, 32'h66); vecs.push_back(r);
      r = mk("t4_dcan_iss"); r.di_v = 1; r.di_rd = 8; vecs.push_back(r);
      r = mk("t4_dcan"); r.dc = 1; r.dr_v = 1; r.dr_data = 32'h77; r.ra0 = 8; r.e_busy = 3'b100; vecs.push_back(r);
      r = mk("t4_dcan_done"); r.ra0 = 8; vecs.push_back(r);

      // 5: fill all tags, cancel, return on a freed tag
      r = mk("t5_iss0"); r.ni_v = 1; r.ni_tag = 0; r.ni_rd = 10; vecs.push_back(r);
      r = mk("t5_iss1"); r.ni_v = 1; r.ni_tag = 1; r.ni_rd = 11; vecs.push_back(r);
      r = mk("t5_iss2"); r.ni_v = 1; r.ni_tag = 2; r.ni_rd = 12; vecs.push_back(r);
      r = mk("t5_iss3"); r.ni_v = 1; r.ni_tag = 3; r.ni_rd = 13; vecs.push_back(r);
      r = mk("t5_full"); r.nc_v = 1; r.nc_tag = 2; r.ra0 = 12; r.e_busy = 3'b100; r.e_full = 1; vecs.push_back(r);
      r = mk("t5_cancelled"); r.ra0 = 12; vecs.push_back(r);
      r = mk("t5_ret_bad"); r.nr_v = 1; r.nr_tag = 2; r.nr_data = 32'hBAD; vecs.push_back(r);
      exp_err = 1'b1;
      r = mk("t5_ret0"); r.nr_v = 1; r.nr_tag = 0; r.nr_data = 32'hA0; r.e_p1 = wp(10, 32'hA0); vecs.push_back(r);

      // 6: destination x0 is never busy nor written
      r = mk("t6_rd0"); r.ni_v = 1; r.ni_tag = 2; r.ni_rd = 0; r.pw_v = 1; r.pw_rd = 0; r.pw_data = 32'h123;
      vecs.push_back(r);
      r = mk("t6_ret_rd0"); r.nr_v = 1; r.nr_tag = 2; r.nr_data = 32'h99; vecs.push_back(r); exp_stale++;
      r = mk("t6_fill0"); r.ni_v = 1; r.ni_tag = 0; r.ni_rd = 15; r.di_v = 1; r.di_rd = 14; vecs.push_back(r);
      r = mk("t6_fill2"); r.ni_v = 1; r.ni_tag = 2; r.ni_rd = 16; vecs.push_back(r);
      r = mk("t6_pending"); r.ra0 = 11; r.ra1 = 13; r.drd = 14; r.e_busy = 3'b111; r.e_full = 1; vecs.push_back(r);

      // clock/reset
      drive(mk("idle"));
      repeat (3) @(negedge clk);
      rst_l = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         apply(vecs[i]);
      end

      // asynchronous reset mid-cycle with entries pending
      #1;
      rst_l = 1'b0;
      exp_err = 1'b0;
      exp_stale = 16'd0;
      #1;
      r = mk("rst_async");
      exp_q.push_back(exp_word(r));
      check(r.name);
      @(negedge clk);
      rst_l = 1'b1;

      @(posedge clk); #1;
      r = mk("rst_ret"); r.nr_v = 1; r.nr_tag = 1; r.nr_data = 32'h5; r.dr_v = 1; r.dr_data = 32'h6; r.ra0 = 11;
      apply(r);
      exp_err = 1'b1;
      @(posedge clk); #1;
      apply(mk("rst_err"));

      @(posedge clk); #1;
      drive(mk("idle"));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
